// File: rtl/cm_pkg.sv
// Shared helpers for the cm_* vector blocks (sort/unsort family).
package cm_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int sclog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cm_pipe_vld.sv
// Valid-qualified delay line: REG_CNT cycles latency, one word per cycle.
// No backpressure; payload loads only with valid and otherwise holds.
module cm_pipe_vld #(
  parameter int WIDTH   = 1,
  parameter int REG_CNT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic [REG_CNT-1:0]            vld_q;
  logic [REG_CNT-1:0][WIDTH-1:0] dat_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= i_vld;
      if (i_vld) dat_q[0] <= i_dat;
      for (int s = 1; s < REG_CNT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign o_vld = vld_q[REG_CNT-1];
  assign o_dat = dat_q[REG_CNT-1];

endmodule

// File: rtl/cm_unsort.sv
// Scatters a sorted vector back to original positions and flags non-permutation indices.
// Latency REG_CNT cycles, one vector per cycle, no backpressure (valid-only).
module cm_unsort
  import cm_pkg::*;
#(
  parameter  int DCNT       = 8,
  parameter  int DWIDTH     = 16,
  parameter  int REG_CNT    = 1,
  parameter  int ECNT_WIDTH = 8,
  localparam int IDX_WIDTH  = sclog2(DCNT)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_vld,
  input  logic [DCNT-1:0][IDX_WIDTH-1:0]    i_idx,
  input  logic [DCNT-1:0][DWIDTH-1:0]       i_data,
  output logic                              o_vld,
  output logic [DCNT-1:0][DWIDTH-1:0]       o_data,
  output logic                              o_err,
  output logic [ECNT_WIDTH-1:0]             o_err_cnt
);

  logic [DCNT-1:0][DWIDTH-1:0] scat;
  logic [DCNT-1:0]             hit;
  logic                        err;
  logic [DCNT*DWIDTH:0]        pipe_in;
  logic [DCNT*DWIDTH:0]        pipe_out;

  // Descending k so the lowest matching source index wins; out-of-range
  // indices never equal any p < DCNT and so drop out naturally.
  always_comb begin
    scat = '0;
    hit  = '0;
    for (int p = 0; p < DCNT; p++) begin
      for (int k = DCNT - 1; k >= 0; k--) begin
        if (i_idx[k] == IDX_WIDTH'(p)) begin
          scat[p] = i_data[k];
          hit[p]  = 1'b1;
        end
      end
    end
  end

  // DCNT sources covering all DCNT slots is exactly a permutation.
  assign err     = ~&hit;
  assign pipe_in = {err, scat};

  cm_pipe_vld #(
    .WIDTH   (DCNT * DWIDTH + 1),
    .REG_CNT (REG_CNT)
  ) u_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_vld (i_vld),
    .i_dat (pipe_in),
    .o_vld (o_vld),
    .o_dat (pipe_out)
  );

  assign o_err  = pipe_out[DCNT*DWIDTH];
  assign o_data = pipe_out[DCNT*DWIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_cnt <= '0;
    end else if (o_vld && o_err && !(&o_err_cnt)) begin
      o_err_cnt <= o_err_cnt + ECNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cm_unsort.sv
// Directed bench for cm_unsort: vector table, saturation, round trip, out-of-range, mid-flight reset.
module tb_cm_unsort;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Instance A: DCNT=4, REG_CNT=1, ECNT_WIDTH=2
  logic              a_vld;
  logic [3:0][1:0]   a_idx;
  logic [3:0][15:0]  a_data;
  logic              a_ovld, a_oerr;
  logic [3:0][15:0]  a_odata;
  logic [1:0]        a_ecnt;

  // Instance B: DCNT=8, REG_CNT=2
  logic              b_vld;
  logic [7:0][2:0]   b_idx;
  logic [7:0][15:0]  b_data;
  logic              b_ovld, b_oerr;
  logic [7:0][15:0]  b_odata;
  logic [7:0]        b_ecnt;

  // Instance C: DCNT=6, REG_CNT=3
  logic              c_vld;
  logic [5:0][2:0]   c_idx;
  logic [5:0][15:0]  c_data;
  logic              c_ovld, c_oerr;
  logic [5:0][15:0]  c_odata;
  logic [7:0]        c_ecnt;

  cm_unsort #(.DCNT(4), .DWIDTH(16), .REG_CNT(1), .ECNT_WIDTH(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_vld(a_vld), .i_idx(a_idx), .i_data(a_data),
    .o_vld(a_ovld), .o_data(a_odata), .o_err(a_oerr), .o_err_cnt(a_ecnt));

  cm_unsort #(.DCNT(8), .DWIDTH(16), .REG_CNT(2), .ECNT_WIDTH(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_vld(b_vld), .i_idx(b_idx), .i_data(b_data),
    .o_vld(b_ovld), .o_data(b_odata), .o_err(b_oerr), .o_err_cnt(b_ecnt));

  cm_unsort #(.DCNT(6), .DWIDTH(16), .REG_CNT(3), .ECNT_WIDTH(8)) u_c (
    .i_clk(clk), .i_rst(rst), .i_vld(c_vld), .i_idx(c_idx), .i_data(c_data),
    .o_vld(c_ovld), .o_data(c_odata), .o_err(c_oerr), .o_err_cnt(c_ecnt));

  typedef struct {
    logic [3:0][1:0]  idx;
    logic [3:0][15:0] data;
    logic [3:0][15:0] exp;
    logic             err;
  } vec_t;

  vec_t tab[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a_idx  = 8'($urandom);
    a_data = {$urandom, $urandom};
    b_idx  = 24'($urandom);
    b_data = {$urandom, $urandom, $urandom, $urandom};
    c_idx  = 18'($urandom);
    c_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_vld = 1'b1; b_vld = 1'b1; c_vld = 1'b1;
    scramble();
    tick();
    tick();
    rst = 1'b0;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    tick();
  endtask

  // Reference for the round trip: stable ascending sort with original positions.
  task automatic ref_sort(input logic [7:0][15:0] orig,
                          output logic [7:0][15:0] srt, output logic [7:0][2:0] sidx);
    int ord[8];
    int t;
    for (int i = 0; i < 8; i++) ord[i] = i;
    for (int i = 1; i < 8; i++) begin
      for (int j = i; j > 0; j--) begin
        if (orig[ord[j-1]] > orig[ord[j]]) begin
          t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      srt[k]  = orig[ord[k]];
      sidx[k] = 3'(ord[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0]       ecnt_exp;
    logic [7:0][15:0] orig, srt;
    logic [7:0][2:0]  sidx;
    logic [127:0]     q_dat[$];
    int               q_cyc[$];
    int               cyc, nout, lat_bad, seen_vld;

    // idx/data listed as {elem3, elem2, elem1, elem0}
    tab[0] = '{idx: {2'd1, 2'd3, 2'd0, 2'd2}, data: {16'd40, 16'd30, 16'd20, 16'd10},
               exp: {16'd30, 16'd10, 16'd40, 16'd20}, err: 1'b0};
    tab[1] = '{idx: {2'd3, 2'd2, 2'd1, 2'd1}, data: {16'd8, 16'd7, 16'd6, 16'd5},
               exp: {16'd8, 16'd7, 16'd5, 16'd0}, err: 1'b1};
    tab[2] = '{idx: {2'd3, 2'd2, 2'd1, 2'd0}, data: {16'd4, 16'd3, 16'd2, 16'd1},
               exp: {16'd4, 16'd3, 16'd2, 16'd1}, err: 1'b0};
    tab[3] = '{idx: {2'd0, 2'd1, 2'd2, 2'd3}, data: {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
               exp: {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}, err: 1'b0};
    tab[4] = '{idx: {2'd0, 2'd0, 2'd0, 2'd0}, data: {16'd6, 16'd7, 16'd8, 16'd9},
               exp: {16'd0, 16'd0, 16'd0, 16'd9}, err: 1'b1};
    tab[5] = '{idx: {2'd0, 2'd3, 2'd2, 2'd1}, data: {16'd3, 16'd2, 16'd1, 16'hFFFF},
               exp: {16'd2, 16'd1, 16'hFFFF, 16'd3}, err: 1'b0};

    do_reset();
    chk("rst a_vld",  a_ovld,  0);
    chk("rst a_data", a_odata, 0);
    chk("rst a_err",  a_oerr,  0);
    chk("rst a_ecnt", a_ecnt,  0);
    chk("rst b_vld",  b_ovld,  0);
    chk("rst c_vld",  c_ovld,  0);
    chk("rst c_data", c_odata, 0);

    // Table: each vector then one idle cycle with garbage inputs
    ecnt_exp = 2'd0;
    for (int i = 0; i < 6; i++) begin
      a_vld = 1'b1; a_idx = tab[i].idx; a_data = tab[i].data;
      tick();
      a_vld = 1'b0; scramble();
      chk($sformatf("tab%0d vld", i),  a_ovld,  1);
      chk($sformatf("tab%0d data", i), a_odata, tab[i].exp);
      chk($sformatf("tab%0d err", i),  a_oerr,  tab[i].err);
      tick();
      if (tab[i].err && ecnt_exp != 2'd3) ecnt_exp = ecnt_exp + 2'd1;
      chk($sformatf("tab%0d idle vld", i),  a_ovld,  0);
      chk($sformatf("tab%0d hold data", i), a_odata, tab[i].exp);
      chk($sformatf("tab%0d hold err", i),  a_oerr,  tab[i].err);
      chk($sformatf("tab%0d ecnt", i),      a_ecnt,  ecnt_exp);
    end

    // Saturation: 5 back-to-back erroneous vectors -> 1,2,3,3,3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a_vld = 1'b1; a_idx = tab[1].idx; a_data = tab[1].data;
      tick();
      if (i >= 1) chk($sformatf("sat ecnt%0d", i), a_ecnt, (i < 3) ? i : 3);
    end
    a_vld = 1'b0;
    tick();
    chk("sat ecnt5", a_ecnt, 3);

    // Round trip through a reference sort, 200 back-to-back vectors
    cyc = 0; nout = 0; lat_bad = 0;
    for (int n = 0; n < 206; n++) begin
      if (n < 200) begin
        for (int k = 0; k < 8; k++) orig[k] = 16'($urandom_range(0, 31));
        ref_sort(orig, srt, sidx);
        b_vld = 1'b1; b_idx = sidx; b_data = srt;
        q_dat.push_back(128'(orig));
        q_cyc.push_back(cyc + 2);
      end else begin
        b_vld = 1'b0;
        scramble();
      end
      tick();
      cyc++;
      if (b_ovld) begin
        if (q_dat.size() == 0) begin
          chk("rt extra o_vld", 1, 0);
        end else begin
          chk($sformatf("rt data%0d", nout), b_odata, q_dat.pop_front());
          chk($sformatf("rt err%0d", nout),  b_oerr,  0);
          if (q_cyc.pop_front() != cyc) lat_bad++;
          nout++;
        end
      end
    end
    chk("rt count",   nout,    200);
    chk("rt latency", lat_bad, 0);
    chk("rt ecnt",    b_ecnt,  0);

    // Out of range index, DCNT=6, latency 3
    c_vld = 1'b1;
    c_idx  = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    c_data = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    c_vld = 1'b0; scramble();
    chk("oor vld c1", c_ovld, 0);
    tick();
    chk("oor vld c2", c_ovld, 0);
    tick();
    chk("oor vld c3", c_ovld, 1);
    chk("oor data",   c_odata, {16'd0, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    chk("oor err",    c_oerr, 1);
    tick();
    chk("oor ecnt",   c_ecnt, 1);

    // Reset mid-flight: valid on cycles 0,1,2 with reset on cycle 2
    seen_vld = 0;
    c_vld = 1'b1;
    c_idx  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    c_data = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    if (c_ovld) seen_vld++;
    tick();
    if (c_ovld) seen_vld++;
    rst = 1'b1;
    tick();
    if (c_ovld) seen_vld++;
    rst = 1'b0; c_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (c_ovld) seen_vld++;
    end
    chk("mid rst no vld", seen_vld, 0);
    chk("mid rst data",   c_odata,  0);
    chk("mid rst err",    c_oerr,   0);
    chk("mid rst ecnt",   c_ecnt,   0);

    c_vld = 1'b1;
    c_idx  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    c_data = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    c_vld = 1'b0; scramble();
    chk("post rst vld c1", c_ovld, 0);
    tick();
    chk("post rst vld c2", c_ovld, 0);
    tick();
    chk("post rst vld c3", c_ovld, 1);
    chk("post rst data",   c_odata, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6});
    chk("post rst err",    c_oerr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
